// File: rtl/mem_stage.sv
// Memory-access stage: issues a req/ready/rvalid data-memory transaction for loads and stores,
// formats load/store data, and returns a registered completion pulse with the write-back value.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        completed,
  output logic [31:0] result,
  output logic        fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;

  logic        is_load_q, is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, sd_q;
  logic        latch_en;

  logic        completed_q, completed_d;
  logic        fault_q, fault_d;
  logic [31:0] result_q, result_d;

  logic        is_mem;
  logic        op_fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  assign is_mem   = is_load | is_store;
  assign latch_en = (state_q == StIdle) & enabled;

  // Alignment / width legality of the incoming operation, judged on the raw inputs.
  always_comb begin
    op_fault = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b100: op_fault = 1'b0;
        3'b001, 3'b101: op_fault = alu_result[0];
        3'b010:         op_fault = |alu_result[1:0];
        default:        op_fault = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000:  op_fault = 1'b0;
        3'b001:  op_fault = alu_result[0];
        3'b010:  op_fault = |alu_result[1:0];
        default: op_fault = 1'b1;
      endcase
    end
  end

  // Load extraction uses the latched byte offset, since alu_result may have moved on.
  always_comb begin
    ld_byte   = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    ld_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    st_wdata = sd_q;
    st_wstrb = 4'b1111;
    case (funct3_q[1:0])
      2'b00: begin
        st_wdata = {4{sd_q[7:0]}};
        st_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {2{sd_q[15:0]}};
        st_wstrb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_wdata = sd_q;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enabled && is_mem && !op_fault) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d = is_store_q ? StIdle : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_we    = mem_req & is_store_q;
    mem_wstrb = mem_we ? st_wstrb : 4'b0000;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = st_wdata;
    busy      = (state_q != StIdle);
    completed = completed_q;
    result    = result_q;
    fault     = fault_q;
  end

  // Completion datapath: result and fault are held between completions.
  always_comb begin
    completed_d = 1'b0;
    result_d    = result_q;
    fault_d     = fault_q;
    unique case (state_q)
      StIdle: begin
        if (enabled && (!is_mem || op_fault)) begin
          completed_d = 1'b1;
          result_d    = alu_result;
          fault_d     = op_fault;
        end
      end
      StReq: begin
        if (mem_ready && is_store_q) begin
          completed_d = 1'b1;
          result_d    = 32'h0;
          fault_d     = 1'b0;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          completed_d = 1'b1;
          result_d    = load_data;
          fault_d     = 1'b0;
        end
      end
      default: completed_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      sd_q        <= 32'h0;
      completed_q <= 1'b0;
      fault_q     <= 1'b0;
      result_q    <= 32'h0;
    end else begin
      if (latch_en) begin
        is_load_q  <= is_load;
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= alu_result;
        sd_q       <= store_data;
      end
      completed_q <= completed_d;
      fault_q     <= fault_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of single operations with a small memory responder,
// plus hand-written back-to-back and reset-abort sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, completed, fault;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .enabled    (enabled),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .completed  (completed),
    .result     (result),
    .fault      (fault)
  );

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          rdy_lat;   // REQ cycles with ready low before acceptance
    int          rv_lat;    // WAIT cycle index (1 = first) in which rvalid rises
    bit          stray;     // pulse rvalid during ready-low REQ cycles
    logic [31:0] exp_res;
    logic        exp_fault;
    int          exp_lat;
    int          exp_reqs;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".completed"}, 32'(completed), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".result"}, result, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic do_op(input vec_t v);
    int  cyc;
    int  req_cnt;
    int  wait_cnt;
    int  done_cyc;
    bit  done;
    @(negedge clk);
    enabled    = 1'b1;
    is_load    = v.ld;
    is_store   = v.st;
    funct3     = v.f3;
    alu_result = v.alu;
    store_data = v.sd;
    mem_rdata  = v.rdata;
    @(negedge clk);
    enabled    = 1'b0;
    alu_result = 32'h5A5A_5A5A;  // latched copy must be used from here on
    cyc = 1; req_cnt = 0; wait_cnt = 0; done = 1'b0; done_cyc = -1;
    while (!done && cyc < 40) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        chk({v.name, ".mem_addr"}, mem_addr, v.exp_addr);
        chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({v.name, ".mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
        chk({v.name, ".mem_we"}, 32'(mem_we), 32'(v.st));
        if (req_cnt >= v.rdy_lat) mem_ready = 1'b1;
        else if (v.stray) mem_rvalid = 1'b1;
        req_cnt++;
      end else if (busy) begin
        wait_cnt++;
        if (wait_cnt >= v.rv_lat) mem_rvalid = 1'b1;
      end
      if (completed) begin
        chk({v.name, ".result"}, result, v.exp_res);
        chk({v.name, ".fault"}, 32'(fault), 32'(v.exp_fault));
        chk({v.name, ".busy_at_done"}, 32'(busy), 32'd0);
        done_cyc = cyc;
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout: no completed after %0d cycles", v.name, cyc);
    end
    chk({v.name, ".latency"}, 32'(done_cyc), 32'(v.exp_lat));
    chk({v.name, ".req_cycles"}, 32'(req_cnt), 32'(v.exp_reqs));
    chk({v.name, ".single_pulse"}, 32'(completed), 32'd0);
  endtask

  function automatic vec_t mk(input string name, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                              input logic [31:0] rdata, input int rdy_lat, input int rv_lat,
                              input bit stray, input logic [31:0] exp_res, input logic exp_fault,
                              input int exp_lat, input int exp_reqs, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.alu = alu; v.sd = sd; v.rdata = rdata;
    v.rdy_lat = rdy_lat; v.rv_lat = rv_lat; v.stray = stray; v.exp_res = exp_res;
    v.exp_fault = exp_fault; v.exp_lat = exp_lat; v.exp_reqs = exp_reqs; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.exp_wstrb = exp_wstrb;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    vecs[0]  = mk("pass", 0, 0, 3'b000, 32'hDEADBEEF, 0, 0, 0, 1, 0,
                  32'hDEADBEEF, 0, 1, 0, 0, 0, 4'h0);
    vecs[1]  = mk("lb_103", 1, 0, 3'b000, 32'h103, 0, 32'h80FF7F01, 0, 1, 0,
                  32'hFFFFFF80, 0, 3, 1, 32'h100, 0, 4'h0);
    vecs[2]  = mk("lbu_103", 1, 0, 3'b100, 32'h103, 0, 32'h80FF7F01, 0, 1, 0,
                  32'h00000080, 0, 3, 1, 32'h100, 0, 4'h0);
    vecs[3]  = mk("sh_22", 0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 2, 1, 0,
                  32'h0, 0, 4, 3, 32'h20, 32'hABCDABCD, 4'b1100);
    vecs[4]  = mk("lw_41", 1, 0, 3'b010, 32'h41, 0, 0, 0, 1, 0,
                  32'h41, 1, 1, 0, 0, 0, 4'h0);
    vecs[5]  = mk("ld_f3_011", 1, 0, 3'b011, 32'h40, 0, 0, 0, 1, 0,
                  32'h40, 1, 1, 0, 0, 0, 4'h0);
    vecs[6]  = mk("lh_6", 1, 0, 3'b001, 32'h6, 0, 32'h80017FFF, 1, 5, 1,
                  32'hFFFF8001, 0, 8, 2, 32'h4, 0, 4'h0);
    vecs[7]  = mk("lhu_102", 1, 0, 3'b101, 32'h102, 0, 32'hFEDC1234, 0, 1, 0,
                  32'h0000FEDC, 0, 3, 1, 32'h100, 0, 4'h0);
    vecs[8]  = mk("lw_200", 1, 0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 0, 2, 0,
                  32'hCAFEF00D, 0, 4, 1, 32'h200, 0, 4'h0);
    vecs[9]  = mk("sb_13", 0, 1, 3'b000, 32'h13, 32'h000000A5, 0, 0, 1, 0,
                  32'h0, 0, 2, 1, 32'h10, 32'hA5A5A5A5, 4'b1000);
    vecs[10] = mk("sw_30", 0, 1, 3'b010, 32'h30, 32'h11223344, 0, 1, 1, 0,
                  32'h0, 0, 3, 2, 32'h30, 32'h11223344, 4'b1111);
    vecs[11] = mk("sw_32", 0, 1, 3'b010, 32'h32, 32'h11223344, 0, 0, 1, 0,
                  32'h32, 1, 1, 0, 0, 0, 4'h0);
    vecs[12] = mk("st_f3_100", 0, 1, 3'b100, 32'h60, 32'h1, 0, 0, 1, 0,
                  32'h60, 1, 1, 0, 0, 0, 4'h0);
    vecs[13] = mk("lb_101", 1, 0, 3'b000, 32'h101, 0, 32'h80FF7F01, 0, 1, 0,
                  32'h0000007F, 0, 3, 1, 32'h100, 0, 4'h0);
    vecs[14] = mk("lh_1", 1, 0, 3'b001, 32'h1, 0, 0, 0, 1, 0,
                  32'h1, 1, 1, 0, 0, 0, 4'h0);

    rst = 1'b1; enabled = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    alu_result = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 15; i++) do_op(vecs[i]);

    // Back-to-back pass-through: second enable sampled in the completion cycle.
    @(negedge clk);
    enabled = 1'b1; is_load = 1'b0; is_store = 1'b0; alu_result = 32'h1111_0001;
    @(negedge clk);
    chk("b2b.completed1", 32'(completed), 32'd1);
    chk("b2b.result1", result, 32'h1111_0001);
    alu_result = 32'h2222_0002;
    @(negedge clk);
    enabled = 1'b0;
    chk("b2b.completed2", 32'(completed), 32'd1);
    chk("b2b.result2", result, 32'h2222_0002);
    @(negedge clk);
    chk("b2b.completed3", 32'(completed), 32'd0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    enabled = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    alu_result = 32'h50; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    enabled = 1'b0;
    chk("rstw.req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rstw.busy_wait", 32'(busy), 32'd1);
    chk("rstw.req_wait", 32'(mem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("rstw");
    rst = 1'b0;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rstw.late_rvalid", 32'(completed), 32'd0);
    @(negedge clk);
    chk("rstw.late_rvalid2", 32'(completed), 32'd0);
    chk("rstw.result", result, 32'd0);
    is_load = 1'b0;
    do_op(mk("rstw_pass", 0, 0, 3'b000, 32'h0BAD_F00D, 0, 0, 0, 1, 0,
             32'h0BAD_F00D, 0, 1, 0, 0, 0, 4'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
